// File: rtl/mem_requester.sv
// Host-command to memory sequencer: runs read, write and key-access operations against a
// registered-read memory. Optional MEM_DECODE_EN undoes the 0x0324 key transform on read data.
module mem_requester #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int KEY_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [KEY_W-1:0]  cmd_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic [KEY_W-1:0]  mem_key,
  input  logic [KEY_W-1:0]  mem_key_echo,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_KEY = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, KEY_REL, RESP} state_t;

  state_t            state, state_nx;
  logic [1:0]        op_q, op_nx;
  logic [KEY_W-1:0]  key_q, key_nx;
  logic              cmd_ready_nx, rsp_valid_nx, rsp_err_nx, mem_write_nx;
  logic [DATA_W-1:0] rsp_rdata_nx, wdata_nx, capture_data;
  logic [ADDR_W-1:0] addr_nx;
  logic [KEY_W-1:0]  mem_key_nx;

`ifdef MEM_DECODE_EN
  assign capture_data = ((mem_read_data >> 1) - DATA_W'(21)) ^ DATA_W'('h3F);
`else
  assign capture_data = mem_read_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= OP_RD;
      key_q          <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_key        <= '0;
    end else begin
      state          <= state_nx;
      op_q           <= op_nx;
      key_q          <= key_nx;
      cmd_ready      <= cmd_ready_nx;
      rsp_valid      <= rsp_valid_nx;
      rsp_rdata      <= rsp_rdata_nx;
      rsp_err        <= rsp_err_nx;
      mem_address    <= addr_nx;
      mem_write_data <= wdata_nx;
      mem_write      <= mem_write_nx;
      mem_key        <= mem_key_nx;
    end
  end

  // Every output is registered, so each branch computes the value for the coming state.
  always_comb begin
    state_nx     = state;
    op_nx        = op_q;
    key_nx       = key_q;
    cmd_ready_nx = 1'b0;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    addr_nx      = mem_address;
    wdata_nx     = mem_write_data;
    mem_write_nx = 1'b0;
    mem_key_nx   = '0;

    unique case (state)
      IDLE: begin
        cmd_ready_nx = 1'b1;
        if (cmd_valid) begin
          state_nx     = ISSUE;
          cmd_ready_nx = 1'b0;
          op_nx        = cmd_op;
          key_nx       = cmd_key;
          addr_nx      = cmd_addr;
          wdata_nx     = cmd_wdata;
          rsp_rdata_nx = '0;
          rsp_err_nx   = 1'b0;
          mem_write_nx = (cmd_op == OP_WR);
          if (cmd_op == OP_KEY && cmd_key != '0) mem_key_nx = cmd_key;
        end
      end
      ISSUE: begin
        unique case (op_q)
          OP_RD:  state_nx = CAPTURE;
          OP_WR: begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
          end
          OP_KEY: begin
            if (key_q != '0) begin
              state_nx = KEY_REL;
            end else begin
              state_nx     = RESP;
              rsp_valid_nx = 1'b1;
              rsp_err_nx   = 1'b1;
            end
          end
          default: begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
          end
        endcase
      end
      CAPTURE: begin
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        rsp_rdata_nx = capture_data;
      end
      KEY_REL: begin
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        rsp_err_nx   = (mem_key_echo != key_q);
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          cmd_ready_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed self-checking bench for mem_requester with a registered-read memory model
// that applies the 0x0324 key transform to reads once unlocked.
module tb_mem_requester;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int KEY_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [KEY_W-1:0]  cmd_key;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_write;
  logic [KEY_W-1:0]  mem_key, mem_key_echo;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_key(mem_key), .mem_key_echo(mem_key_echo), .mem_read_data(mem_read_data)
  );

  // Memory model: registered read, echo of the key one cycle later, unlock on 0x0324.
  logic [DATA_W-1:0] memArray [0:1023];
  logic              unlocked = 1'b0;
  logic [KEY_W-1:0]  echoCorrupt = '0;

  function automatic logic [DATA_W-1:0] encodeWord(input logic [DATA_W-1:0] w);
    return ((w ^ 32'h3F) + 32'd21) << 1;
  endfunction

  always @(posedge clk) begin
    if (mem_write) memArray[mem_address] <= mem_write_data;
    mem_read_data <= unlocked ? encodeWord(memArray[mem_address]) : memArray[mem_address];
    mem_key_echo  <= mem_key ^ echoCorrupt;
    if (mem_key == 16'h0324) unlocked <= 1'b1;
  end

  // Activity monitors sampled mid-cycle.
  int               writeCycles = 0;
  int               keyCycles   = 0;
  logic [KEY_W-1:0] lastKey     = '0;

  always @(negedge clk) begin
    if (mem_write) writeCycles++;
    if (mem_key != '0) begin
      keyCycles++;
      lastKey = mem_key;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [KEY_W-1:0] key);
    int n = 0;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_key   = key;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic getResponse(input string tag, input int expLat, input logic [31:0] expData,
                             input logic expErr, input int hold);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_rdata"}, rsp_rdata, expData);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, rsp_rdata, expData);
      checkOutput({tag, "_hold_err"}, 32'(rsp_err), 32'(expErr));
      checkOutput({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_retired"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, "_mem_key"}, 32'(mem_key), 32'd0);
    checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    checkOutput({tag, "_mem_write_data"}, mem_write_data, 32'd0);
  endtask

`ifdef MEM_DECODE_EN
  localparam logic [31:0] EXP_A8    = 32'h0000_0000;
  localparam logic [31:0] EXP_WRITE = 32'h091A_2B18;
  localparam logic [31:0] EXP_KEYED = 32'h0000_00A8;
`else
  localparam logic [31:0] EXP_A8    = 32'h0000_00A8;
  localparam logic [31:0] EXP_WRITE = 32'h1234_5678;
  localparam logic [31:0] EXP_KEYED = 32'h0000_0158;
`endif

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int w0, k0;
    for (int i = 0; i < 1024; i++) memArray[i] = 32'hA8;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_key   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] read at power-up value, response held 3 cycles");
    applyStimulus(2'b00, 10'd5, 32'h0, 16'h0);
    getResponse("read5", 3, EXP_A8, 1'b0, 3);

    $display("[TB] write then read back");
    w0 = writeCycles;
    applyStimulus(2'b01, 10'd3, 32'h1234_5678, 16'h0);
    getResponse("write3", 2, 32'h0, 1'b0, 0);
    checkOutput("write3_pulse_count", writeCycles - w0, 1);
    applyStimulus(2'b00, 10'd3, 32'h0, 16'h0);
    getResponse("read3", 3, EXP_WRITE, 1'b0, 0);

    $display("[TB] key access then keyed read");
    k0 = keyCycles;
    applyStimulus(2'b10, 10'd0, 32'h0, 16'h0324);
    getResponse("key", 3, 32'h0, 1'b0, 0);
    checkOutput("key_cycles", keyCycles - k0, 1);
    checkOutput("key_value", 32'(lastKey), 32'h0324);
    checkOutput("key_released", 32'(mem_key), 32'h0);
    applyStimulus(2'b00, 10'd7, 32'h0, 16'h0);
    getResponse("read7", 3, EXP_KEYED, 1'b0, 0);

    $display("[TB] illegal op and zero key");
    w0 = writeCycles;
    k0 = keyCycles;
    applyStimulus(2'b11, 10'd4, 32'hCAFE_F00D, 16'h0324);
    getResponse("illegal", 2, 32'h0, 1'b1, 0);
    applyStimulus(2'b10, 10'd4, 32'h0, 16'h0000);
    getResponse("zerokey", 2, 32'h0, 1'b1, 0);
    checkOutput("err_ops_no_write", writeCycles - w0, 0);
    checkOutput("err_ops_no_key", keyCycles - k0, 0);

    $display("[TB] key echo mismatch");
    echoCorrupt = 16'h0001;
    applyStimulus(2'b10, 10'd0, 32'h0, 16'h0055);
    getResponse("badecho", 3, 32'h0, 1'b1, 0);
    echoCorrupt = '0;

    $display("[TB] reset during capture");
    applyStimulus(2'b00, 10'd5, 32'h0, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("rst_capture");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_capture_no_rsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(2'b00, 10'd7, 32'h0, 16'h0);
    getResponse("post_rst_read7", 3, EXP_KEYED, 1'b0, 0);

    $display("[TB] reset during write issue");
    applyStimulus(2'b01, 10'd9, 32'hDEAD_BEEF, 16'h0);
    checkOutput("rst_write_pulse_before", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1 checkResetOutputs("rst_write");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2'b00, 10'd9, 32'h0, 16'h0);
    getResponse("abandoned_write9", 3, EXP_KEYED, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
